// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core load/store port.
// Latency: rsp_valid rises LATENCY+1 cycles after the accepting edge. One transaction every LATENCY+3 cycles.
// Backpressure: one transaction in flight; req_ready is low until the response is taken. The response is held while rsp_ready is low.
//
// Ports:
//   clk, reset (synchronous, active low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be : request channel (valid/ready)
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                : response channel (valid/ready)
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // First byte address past the end of the backing array.
  // One extra bit so the limit is representable even when the array spans
  // the whole address space.
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;

  localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH_WORDS-1];

  // Operands of the access. With zero latency the access happens on the
  // accepting edge itself, so the live request is used instead of the latch.
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [3:0]            acc_be;
  logic                  acc_fire;
  logic                  acc_in_range;
  logic                  wr_en;
  logic [IDX_W-1:0]      acc_idx;
  logic                  rd_in_range;
  logic [IDX_W-1:0]      rd_idx;

  assign req_ready = (state == S_IDLE);

  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign acc_fire     = ((state == S_IDLE) && req_valid && (LATENCY == 0)) ||
                        ((state == S_WAIT) && (cnt == 4'd0));
  assign acc_in_range = ({1'b0, acc_addr} < LIMIT);
  assign acc_idx      = acc_addr[IDX_W+1:2];
  // The write is gated by reset so a store still waiting when reset hits
  // never reaches the array.
  assign wr_en        = reset && acc_fire && acc_we && acc_in_range;

  assign rd_in_range  = ({1'b0, addr_q} < LIMIT);
  assign rd_idx       = addr_q[IDX_W+1:2];

  // Backing array: byte-lane writes, not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (LATENCY == 0) begin
              state <= S_RESP;
            end else begin
              cnt   <= LAT_M1;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // First RESP cycle registers the result. Any store has already
          // committed on the entry edge, so a read here sees it. Later
          // cycles hold the result until the core takes it.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !rd_in_range;
            rsp_rdata <= (we_q || !rd_in_range) ? '0 : mem[rd_idx];
          end else if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances with LATENCY 2, 4 and 0.
// Instance 0 runs the vector table plus backpressure, instance 1 covers reset mid-operation,
// instance 2 covers zero-latency back-to-back throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .DEPTH_WORDS(1024),
      .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 4 : 0))
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 4 : 0);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] exp_rdata,
                              input logic exp_err, input string name);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    return v;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one full transaction with rsp_ready high. Starts and ends at a negedge
  // with the DUT idle, so consecutive calls are back-to-back.
  task automatic do_txn(input int i, input vec_t v, output int acc_cyc);
    int lat;
    req_valid[i] = 1'b1;
    req_we[i]    = v.we;
    req_addr[i]  = v.addr;
    req_wdata[i] = v.wdata;
    req_be[i]    = v.be;
    rsp_ready[i] = 1'b1;
    check({v.name, " req_ready"}, 32'(req_ready[i]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc      = cyc;
    req_valid[i] = 1'b0;
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      if (rsp_valid[i]) begin
        lat = j;
        break;
      end
      @(negedge clk);
    end
    check({v.name, " latency"}, 32'(lat), 32'(lat_of(i) + 1));
    check({v.name, " rdata"}, rsp_rdata[i], v.exp_rdata);
    check({v.name, " err"}, 32'(rsp_err[i]), 32'(v.exp_err));
    @(negedge clk);
    check({v.name, " post valid"}, 32'(rsp_valid[i]), 32'd0);
    check({v.name, " post ready"}, 32'(req_ready[i]), 32'd1);
    check({v.name, " post rdata"}, rsp_rdata[i], 32'd0);
  endtask

  // Presents a request with rsp_ready low and waits (bounded) for rsp_valid.
  task automatic start_held(input int i, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input string name);
    bit seen;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_be[i]    = 4'hF;
    rsp_ready[i] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (rsp_valid[i]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, " valid seen"}, 32'(seen), 32'd1);
  endtask

  vec_t vecs[$];
  vec_t tv;
  int   a0, a1, a2, dummy;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_be[i] = '0; rsp_ready[i] = 1'b0;
    end

    // Vector table for instance 0 (LATENCY = 2).
    vecs.push_back(mk(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0, "st10"));
    vecs.push_back(mk(1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0, "ld10"));
    vecs.push_back(mk(1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0, "st20"));
    vecs.push_back(mk(1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0, "st20_be5"));
    vecs.push_back(mk(1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0, "ld20_be0"));
    vecs.push_back(mk(1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        1'b0, "st0"));
    vecs.push_back(mk(1'b0, 32'h1000,     32'h0,        4'hF, 32'h0,        1'b1, "ld1000"));
    vecs.push_back(mk(1'b1, 32'h1000,     32'h12345678, 4'hF, 32'h0,        1'b1, "st1000"));
    vecs.push_back(mk(1'b0, 32'h0,        32'h0,        4'hF, 32'hCAFEF00D, 1'b0, "ld0"));
    vecs.push_back(mk(1'b0, 32'h12,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0, "ld12"));
    vecs.push_back(mk(1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, "st10_be0"));
    vecs.push_back(mk(1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0, "ld10_b"));
    vecs.push_back(mk(1'b1, 32'hFFC,      32'h0A0B0C0D, 4'hF, 32'h0,        1'b0, "stFFC"));
    vecs.push_back(mk(1'b0, 32'hFFF,      32'h0,        4'hF, 32'h0A0B0C0D, 1'b0, "ldFFF"));
    vecs.push_back(mk(1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 32'h0,        1'b1, "ldTop"));
    vecs.push_back(mk(1'b1, 32'h10,       32'h77000000, 4'h8, 32'h0,        1'b0, "st10_be8"));
    vecs.push_back(mk(1'b0, 32'h10,       32'h0,        4'hF, 32'h77ADBEEF, 1'b0, "ld10_c"));

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d req_ready", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("reset%0d rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("reset%0d rsp_rdata", i), rsp_rdata[i], 32'd0);
      check($sformatf("reset%0d rsp_err", i), 32'(rsp_err[i]), 32'd0);
      rst_n[i] = 1'b1;
    end
    @(negedge clk);

    foreach (vecs[k]) do_txn(0, vecs[k], dummy);

    // Backpressure: response held for 5 cycles, then released.
    start_held(0, 1'b0, 32'h20, 32'h0, "bp");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d valid", k), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp%0d rdata", k), rsp_rdata[0], 32'h11BB33DD);
      check($sformatf("bp%0d req_ready", k), 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp release valid", 32'(rsp_valid[0]), 32'd0);
    check("bp release ready", 32'(req_ready[0]), 32'd1);
    check("bp release rdata", rsp_rdata[0], 32'd0);

    // Reset while a store is in WAIT (instance 1, LATENCY = 4).
    do_txn(1, mk(1'b1, 32'h40, 32'h13579BDF, 4'hF, 32'h0, 1'b0, "i1 st40"), dummy);
    do_txn(1, mk(1'b1, 32'h44, 32'h0,        4'hF, 32'h0, 1'b0, "i1 st44"), dummy);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h40;
    req_wdata[1] = 32'h55; req_be[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rstwait%0d req_ready", k), 32'(req_ready[1]), 32'd1);
      check($sformatf("rstwait%0d rsp_valid", k), 32'(rsp_valid[1]), 32'd0);
      check($sformatf("rstwait%0d rsp_rdata", k), rsp_rdata[1], 32'd0);
      check($sformatf("rstwait%0d rsp_err", k), 32'(rsp_err[1]), 32'd0);
    end
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("rstwait idle valid", 32'(rsp_valid[1]), 32'd0);
    do_txn(1, mk(1'b0, 32'h40, 32'h0, 4'hF, 32'h13579BDF, 1'b0, "i1 ld40"), dummy);

    // Reset while a store waits in RESP: the store stays committed.
    start_held(1, 1'b1, 32'h44, 32'h66, "rstresp");
    rst_n[1] = 1'b0;
    @(negedge clk);
    check("rstresp valid", 32'(rsp_valid[1]), 32'd0);
    check("rstresp ready", 32'(req_ready[1]), 32'd1);
    rst_n[1] = 1'b1;
    @(negedge clk);
    do_txn(1, mk(1'b0, 32'h44, 32'h0, 4'hF, 32'h66, 1'b0, "i1 ld44"), dummy);

    // Zero latency, back-to-back loads (instance 2).
    do_txn(2, mk(1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, "i2 st8"), dummy);
    tv = mk(1'b0, 32'h8, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, "i2 ld8");
    do_txn(2, tv, a0);
    do_txn(2, tv, a1);
    do_txn(2, tv, a2);
    check("l0 accept gap 1", 32'(a1 - a0), 32'd3);
    check("l0 accept gap 2", 32'(a2 - a1), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
